// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//   Multi-cycle control sequencer for a small RISC-V style datapath. Accepts one
//   instruction at a time from fetch, walks it through DECODE / EXEC / MEM / WB,
//   drives the datapath strobes and counts retired instructions.
//
// Parameters
//   MEM_TIMEOUT   maximum consecutive MEM cycles without mem_ready before mem_fault
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr_valid / instr_ready  fetch handshake (ready only in FETCH)
//   opcode, branch, reg_write,
//   mem_read, mem_write,
//   mem_to_reg                 instruction fields, latched on acceptance
//   branch_taken               ALU branch outcome, sampled in EXEC
//   mem_ready                  data memory access complete
//   alu_en .. illegal          datapath strobes and status pulses
//   state                      current FSM state encoding
//   retired                    retired-instruction count (wraps)
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | waiting for instr_valid; instr_ready high
// DECODE | opcode legality check on latched fields
// EXEC   | ALU cycle; branches/jumps and pure-PC instructions retire here
// MEM    | data access held until mem_ready or timeout
// WB     | register-file write, PC update, retire
// 5..7   | unused encodings, recover to FETCH

module instruction_sequencer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [6:0]  opcode,
  input  logic        branch,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        alu_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        pc_write,
  output logic        pc_src,
  output logic        flush,
  output logic        mem_fault,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [6:0]     op_q;
  logic           br_q, rw_q, mr_q, mw_q, m2r_q;
  logic [WCW-1:0] wait_q;
  logic           wait_tc;
  logic           retire;

  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
      7'b1100011, 7'b1100111, 7'b1101111: opcode_legal = 1'b1;
      default:                            opcode_legal = 1'b0;
    endcase
  endfunction

  // Last allowed MEM cycle: wait_q is 0 on the first MEM cycle.
  assign wait_tc     = (wait_q == WCW'(MEM_TIMEOUT - 1));
  assign instr_ready = (state_q == FETCH);
  assign state       = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      br_q  <= 1'b0;
      rw_q  <= 1'b0;
      mr_q  <= 1'b0;
      mw_q  <= 1'b0;
      m2r_q <= 1'b0;
    end else if (state_q == FETCH && instr_valid) begin
      op_q  <= opcode;
      br_q  <= branch;
      rw_q  <= reg_write;
      mr_q  <= mem_read;
      mw_q  <= mem_write;
      m2r_q <= mem_to_reg;
    end
  end

  // Counts MEM cycles; any non-MEM cycle clears it, so it is zero on MEM entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wait_q <= '0;
    else if (state_q == MEM)    wait_q <= wait_q + WCW'(1);
    else                        wait_q <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired <= '0;
    else if (retire) retired <= retired + 32'd1;
  end

  always_comb begin
    state_d   = state_q;
    alu_en    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    flush     = 1'b0;
    mem_fault = 1'b0;
    illegal   = 1'b0;
    retire    = 1'b0;

    case (state_q)
      FETCH: begin
        if (instr_valid) state_d = DECODE;
      end

      DECODE: begin
        if (opcode_legal(op_q)) begin
          state_d = EXEC;
        end else begin
          illegal = 1'b1;
          state_d = FETCH;
        end
      end

      EXEC: begin
        alu_en = 1'b1;
        if (br_q) begin
          pc_write = 1'b1;
          pc_src   = branch_taken;
          flush    = branch_taken;
          retire   = 1'b1;
          state_d  = FETCH;
        end else if (mr_q || mw_q) begin
          state_d = MEM;
        end else if (rw_q) begin
          state_d = WB;
        end else begin
          pc_write = 1'b1;
          retire   = 1'b1;
          state_d  = FETCH;
        end
      end

      MEM: begin
        mem_req = 1'b1;
        // Read wins when both access bits are latched.
        mem_we  = mw_q & ~mr_q;
        if (mem_ready) begin
          if (mr_q) begin
            state_d = WB;
          end else begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = FETCH;
          end
        end else if (wait_tc) begin
          mem_fault = 1'b1;
          state_d   = FETCH;
        end
      end

      WB: begin
        rf_we    = 1'b1;
        pc_write = 1'b1;
        wb_sel   = m2r_q;
        retire   = 1'b1;
        state_d  = FETCH;
      end

      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer
//   Directed bench for instruction_sequencer. Each cycle inputs are driven 1 ns
//   after the rising edge and outputs are sampled 3 ns after it. Strobes are
//   compared as one packed word:
//   {instr_ready, alu_en, mem_req, mem_we, rf_we, wb_sel, pc_write, pc_src,
//    flush, mem_fault, illegal}

module tb_instruction_sequencer;

  localparam logic [10:0] S_IR    = 11'h400;
  localparam logic [10:0] S_ALU   = 11'h200;
  localparam logic [10:0] S_MREQ  = 11'h100;
  localparam logic [10:0] S_MWE   = 11'h080;
  localparam logic [10:0] S_RFWE  = 11'h040;
  localparam logic [10:0] S_WBSEL = 11'h020;
  localparam logic [10:0] S_PCW   = 11'h010;
  localparam logic [10:0] S_PCSRC = 11'h008;
  localparam logic [10:0] S_FLUSH = 11'h004;
  localparam logic [10:0] S_MFLT  = 11'h002;
  localparam logic [10:0] S_ILL   = 11'h001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, instr_ready;
  logic [6:0]  opcode;
  logic        branch, reg_write, mem_read, mem_write, mem_to_reg;
  logic        branch_taken, mem_ready;
  logic        alu_en, mem_req, mem_we, rf_we, wb_sel, pc_write, pc_src, flush;
  logic        mem_fault, illegal;
  logic [2:0]  state;
  logic [31:0] retired;
  logic [10:0] strb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instruction_sequencer #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .branch(branch), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .alu_en(alu_en), .mem_req(mem_req), .mem_we(mem_we), .rf_we(rf_we),
    .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src), .flush(flush),
    .mem_fault(mem_fault), .illegal(illegal),
    .state(state), .retired(retired)
  );

  assign strb = {instr_ready, alu_en, mem_req, mem_we, rf_we, wb_sel,
                 pc_write, pc_src, flush, mem_fault, illegal};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cyc(input string tag, input logic [2:0] exp_st, input logic [10:0] exp_strb);
    #2;
    check_eq({tag, ".state"}, {29'd0, state}, {29'd0, exp_st});
    check_eq({tag, ".strb"},  {21'd0, strb},  {21'd0, exp_strb});
  endtask

  task automatic drive_instr(input logic [6:0] op, input logic br, input logic rw,
                             input logic mr, input logic mw, input logic m2r);
    instr_valid = 1'b1;
    opcode      = op;
    branch      = br;
    reg_write   = rw;
    mem_read    = mr;
    mem_write   = mw;
    mem_to_reg  = m2r;
  endtask

  // Scrambles the instruction fields so that wrong (unlatched) use shows up.
  task automatic idle_in();
    instr_valid = 1'b0;
    opcode      = 7'h7f;
    branch      = 1'b0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    branch_taken = 1'b0;
    mem_ready    = 1'b0;
    idle_in();

    // Reset state
    repeat (3) tick();
    check_cyc("reset", 3'd0, S_IR);
    check_eq("reset.retired", retired, 32'd0);
    rst_n = 1'b1;

    // R-type with register write: 0,1,2,4 then back to FETCH
    tick(); drive_instr(7'b0110011, 0, 1, 0, 0, 0); check_cyc("r.fetch", 3'd0, S_IR);
    tick(); idle_in();                              check_cyc("r.dec",   3'd1, '0);
    tick();                                         check_cyc("r.exec",  3'd2, S_ALU);
    tick();                                         check_cyc("r.wb",    3'd4, S_RFWE | S_PCW);
    tick();                                         check_cyc("r.done",  3'd0, S_IR);
    check_eq("r.retired", retired, 32'd1);

    // Load, mem_ready on the 2nd MEM cycle, then WB with wb_sel=1
    tick(); drive_instr(7'b0000011, 0, 1, 1, 0, 1); check_cyc("ld.fetch", 3'd0, S_IR);
    tick(); idle_in();                              check_cyc("ld.dec",   3'd1, '0);
    tick();                                         check_cyc("ld.exec",  3'd2, S_ALU);
    tick(); mem_ready = 1'b0;                       check_cyc("ld.mem1",  3'd3, S_MREQ);
    tick(); mem_ready = 1'b1;                       check_cyc("ld.mem2",  3'd3, S_MREQ);
    tick(); mem_ready = 1'b0;                       check_cyc("ld.wb",    3'd4, S_RFWE | S_WBSEL | S_PCW);
    tick();                                         check_cyc("ld.done",  3'd0, S_IR);
    check_eq("ld.retired", retired, 32'd2);

    // Branch taken: retires in EXEC with pc_src and flush
    tick(); drive_instr(7'b1100011, 1, 0, 0, 0, 0); check_cyc("bt.fetch", 3'd0, S_IR);
    tick(); idle_in();                              check_cyc("bt.dec",   3'd1, '0);
    tick(); branch_taken = 1'b1;                    check_cyc("bt.exec",  3'd2, S_ALU | S_PCW | S_PCSRC | S_FLUSH);
    tick(); branch_taken = 1'b0;                    check_cyc("bt.done",  3'd0, S_IR);
    check_eq("bt.retired", retired, 32'd3);

    // Branch not taken: pc_write only
    tick(); drive_instr(7'b1100011, 1, 0, 0, 0, 0); check_cyc("bn.fetch", 3'd0, S_IR);
    tick(); idle_in();                              check_cyc("bn.dec",   3'd1, '0);
    tick();                                         check_cyc("bn.exec",  3'd2, S_ALU | S_PCW);
    tick();                                         check_cyc("bn.done",  3'd0, S_IR);
    check_eq("bn.retired", retired, 32'd4);

    // Store with mem_ready held low: fault on the 16th MEM cycle
    tick(); drive_instr(7'b0100011, 0, 0, 0, 1, 0); check_cyc("stf.fetch", 3'd0, S_IR);
    tick(); idle_in();                              check_cyc("stf.dec",   3'd1, '0);
    tick();                                         check_cyc("stf.exec",  3'd2, S_ALU);
    for (int i = 1; i <= 15; i++) begin
      tick(); check_cyc("stf.memwait", 3'd3, S_MREQ | S_MWE);
    end
    tick();                                         check_cyc("stf.mem16", 3'd3, S_MREQ | S_MWE | S_MFLT);
    tick();                                         check_cyc("stf.done",  3'd0, S_IR);
    check_eq("stf.retired", retired, 32'd4);

    // Store with mem_ready exactly on the 16th MEM cycle: success, no fault
    tick(); drive_instr(7'b0100011, 0, 0, 0, 1, 0); check_cyc("sts.fetch", 3'd0, S_IR);
    tick(); idle_in();                              check_cyc("sts.dec",   3'd1, '0);
    tick();                                         check_cyc("sts.exec",  3'd2, S_ALU);
    for (int i = 1; i <= 15; i++) begin
      tick(); check_cyc("sts.memwait", 3'd3, S_MREQ | S_MWE);
    end
    tick(); mem_ready = 1'b1;                       check_cyc("sts.mem16", 3'd3, S_MREQ | S_MWE | S_PCW);
    tick(); mem_ready = 1'b0;                       check_cyc("sts.done",  3'd0, S_IR);
    check_eq("sts.retired", retired, 32'd5);

    // Illegal opcode, then a legal I-type completes normally
    tick(); drive_instr(7'b0000000, 0, 1, 0, 0, 0); check_cyc("ill.fetch", 3'd0, S_IR);
    tick(); idle_in();                              check_cyc("ill.dec",   3'd1, S_ILL);
    tick();                                         check_cyc("ill.done",  3'd0, S_IR);
    check_eq("ill.retired", retired, 32'd5);
    tick(); drive_instr(7'b0010011, 0, 1, 0, 0, 0); check_cyc("i.fetch", 3'd0, S_IR);
    tick(); idle_in();                              check_cyc("i.dec",   3'd1, '0);
    tick();                                         check_cyc("i.exec",  3'd2, S_ALU);
    tick();                                         check_cyc("i.wb",    3'd4, S_RFWE | S_PCW);
    tick();                                         check_cyc("i.done",  3'd0, S_IR);
    check_eq("i.retired", retired, 32'd6);

    // No register write, no memory: retires from EXEC
    tick(); drive_instr(7'b0010011, 0, 0, 0, 0, 0); check_cyc("nop.fetch", 3'd0, S_IR);
    tick(); idle_in();                              check_cyc("nop.dec",   3'd1, '0);
    tick();                                         check_cyc("nop.exec",  3'd2, S_ALU | S_PCW);
    tick();                                         check_cyc("nop.done",  3'd0, S_IR);
    check_eq("nop.retired", retired, 32'd7);

    // Both mem_read and mem_write latched: behaves as a read
    tick(); drive_instr(7'b0000011, 0, 1, 1, 1, 1); check_cyc("rw.fetch", 3'd0, S_IR);
    tick(); idle_in();                              check_cyc("rw.dec",   3'd1, '0);
    tick();                                         check_cyc("rw.exec",  3'd2, S_ALU);
    tick(); mem_ready = 1'b1;                       check_cyc("rw.mem",   3'd3, S_MREQ);
    tick(); mem_ready = 1'b0;                       check_cyc("rw.wb",    3'd4, S_RFWE | S_WBSEL | S_PCW);
    tick();                                         check_cyc("rw.done",  3'd0, S_IR);
    check_eq("rw.retired", retired, 32'd8);

    // Reset asserted mid-MEM: mem_req drops at once, nothing retires
    tick(); drive_instr(7'b0100011, 0, 0, 0, 1, 0); check_cyc("rst.fetch", 3'd0, S_IR);
    tick(); idle_in();                              check_cyc("rst.dec",   3'd1, '0);
    tick();                                         check_cyc("rst.exec",  3'd2, S_ALU);
    tick();                                         check_cyc("rst.mem",   3'd3, S_MREQ | S_MWE);
    rst_n = 1'b0;
    #1;
    check_eq("rst.async_state", {29'd0, state}, 32'd0);
    check_eq("rst.async_strb",  {21'd0, strb},  {21'd0, S_IR});
    check_eq("rst.async_retired", retired, 32'd0);
    tick(); mem_ready = 1'b1;                       check_cyc("rst.held", 3'd0, S_IR);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    tick();                                         check_cyc("rst.after", 3'd0, S_IR);
    check_eq("rst.retired", retired, 32'd0);

    // Retire counter wraps from 0xFFFFFFFF to 0
    tick(); drive_instr(7'b1101111, 1, 1, 0, 0, 0); check_cyc("wr.fetch", 3'd0, S_IR);
    tick(); idle_in();
    force dut.retired = 32'hFFFF_FFFF;
    #1;
    release dut.retired;
    check_cyc("wr.dec", 3'd1, '0);
    check_eq("wr.preload", retired, 32'hFFFF_FFFF);
    tick(); branch_taken = 1'b1;                    check_cyc("wr.exec", 3'd2, S_ALU | S_PCW | S_PCSRC | S_FLUSH);
    tick(); branch_taken = 1'b0;                    check_cyc("wr.done", 3'd0, S_IR);
    check_eq("wr.retired", retired, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum consecutive MEM-state cycles without mem_ready before a fault is raised.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port instr_valid  input  1  fetch stage presents an instruction.
REQ-005 SHALL have port instr_ready  output  1  sequencer accepts an instruction this cycle.
REQ-006 SHALL have port opcode  input  7  opcode of the presented instruction.
REQ-007 SHALL have port branch, reg_write, mem_read, mem_write, mem_to_reg  input  1 each  control-unit decode bits for the presented instruction.
REQ-008 SHALL have port branch_taken  input  1  ALU branch outcome, valid in EXEC.
REQ-009 SHALL have port mem_ready  input  1  data memory completes the current access.
REQ-010 SHALL have ports alu_en, mem_req, mem_we, rf_we, wb_sel, pc_write, pc_src, flush, mem_fault, illegal  output  1 each  datapath strobes and status.
REQ-011 SHALL have port state  output  3  current FSM state encoding.
REQ-012 SHALL have port retired  output  32  count of retired instructions.

Function
REQ-013 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL transition to FETCH.
REQ-014 SHALL drive instr_ready=1 only in FETCH (combinational from state).
REQ-015 SHALL, in FETCH with instr_valid=1, latch opcode and all five decode bits and move to DECODE; otherwise stay in FETCH.
REQ-016 SHALL, in DECODE, check the latched opcode against {0110011,0010011,0000011,0100011,1100011,1100111,1101111}; on a miss pulse illegal for one cycle and return to FETCH without retiring; otherwise move to EXEC.
REQ-017 SHALL assert alu_en for exactly one cycle, in EXEC.
REQ-018 SHALL, in EXEC with latched branch=1, pulse pc_write, set pc_src=branch_taken and flush=branch_taken, retire, and return to FETCH.
REQ-019 SHALL, in EXEC with branch=0: go to MEM if mem_read or mem_write; else go to WB if reg_write; else pulse pc_write (pc_src=0), retire, and go to FETCH.
REQ-020 SHALL hold mem_req=1 for every MEM cycle, with mem_we=latched mem_write.
REQ-021 SHALL, in MEM on mem_ready=1: go to WB if mem_read; else pulse pc_write, retire, and go to FETCH.
REQ-022 SHALL count MEM cycles in a wait counter cleared on MEM entry; when mem_ready=0 on the MEM_TIMEOUT-th cycle, pulse mem_fault, return to FETCH, no pc_write, no retire.
REQ-023 SHALL treat mem_ready on the MEM_TIMEOUT-th cycle as success; mem_fault SHALL NOT assert.
REQ-024 SHALL, in WB, assert rf_we and pc_write for one cycle with wb_sel=latched mem_to_reg, retire, and go to FETCH.
REQ-025 SHALL, if both mem_read and mem_write are latched, perform a read (mem_we=0).
REQ-026 SHALL increment retired by 1 per retire event, wrapping 0xFFFFFFFF to 0.
REQ-027 SHALL drive all strobes other than instr_ready low outside their stated states.
REQ-028 SHALL give these latencies from the acceptance cycle to the retire cycle: R/I-ALU 3 cycles; load 4+wait cycles; store 3+wait cycles; branch/jump 2 cycles.

Reset
REQ-029 SHALL, while rst_n=0, force state=FETCH, retired=0, the wait counter to 0, latched bits to 0, and all strobes to 0 except instr_ready=1.
REQ-030 SHALL, on reset asserted mid-instruction (including MEM), drop mem_req immediately and never retire that instruction.

Verification
REQ-031 SHALL cover: R-type opcode 0110011, reg_write=1 -> states 0,1,2,4; rf_we and pc_write at cycle 3; wb_sel=0; retired=1.
REQ-032 SHALL cover: load 0000011 with mem_ready after 2 MEM cycles -> mem_req high 2 cycles, mem_we=0, then WB with wb_sel=1; retired increments.
REQ-033 SHALL cover: branch 1100011 with branch_taken=1 -> pc_write=pc_src=flush=1 in EXEC; no MEM/WB; with branch_taken=0 -> flush=0.
REQ-034 SHALL cover: store 0100011 with mem_ready held 0 -> mem_fault pulse on the 16th MEM cycle, state returns to 0, retired unchanged.
REQ-035 SHALL cover: opcode 0000000 -> illegal pulse in DECODE, no alu_en, retired unchanged; then a valid instruction completes normally.
REQ-036 SHALL cover: rst_n low during MEM -> mem_req=0 and state=0 asynchronously; retired=0x00000000 after preload 0xFFFFFFFF plus one retire.
